// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared FSM state type and board timing constant for the switch debouncer.
package sw_debounce_pkg;
  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;
  localparam int DEBOUNCE_20MS_AT_50MHZ = 1_000_000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one synchronised, stability-filtered input with optional rise/fall pulses.
// Pulse registers exist only when SW_DEBOUNCE_EDGE_EN is defined; otherwise rise/fall are 0.
module debounce_channel
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic sync1, s, clean_n;
  logic [CW-1:0] cnt, cnt_n;
  state_t state, state_n;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      state <= state_n;
      cnt   <= cnt_n;
      clean <= clean_n;
    end
  end
  // A sample matching clean always returns to IDLE, covering both steady state and bounce-back.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clean_n = clean;
    if (s == clean) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == IDLE) begin
      state_n = SETTLE;
      cnt_n   = CW'(1);
    end else if (cnt == LAST) begin
      state_n = IDLE;
      cnt_n   = '0;
      clean_n = s;
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end
`ifdef SW_DEBOUNCE_EDGE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= clean_n & ~clean;
      fall <= ~clean_n & clean;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: WIDTH independent debounced channels with clean level and rise/fall pulses.
// Define SW_DEBOUNCE_EDGE_EN to build the rise/fall pulse registers.
module sw_debounce #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  if (STABLE_CYCLES < 2) begin : g_bad_param
    $error("sw_debounce: STABLE_CYCLES must be at least 2");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch (
      .clock(clock),
      .reset(reset),
      .raw  (raw[i]),
      .clean(clean[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed checks of debounce timing, glitch rejection, reset and edge pulses.
module tb_sw_debounce;
  localparam int WIDTH = 3;
  localparam int SC    = 4;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam logic [2:0] PM = 3'b111;
`else
  localparam logic [2:0] PM = 3'b000;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [WIDTH-1:0] raw = '0;
  logic [WIDTH-1:0] clean, rise, fall;
  int checks = 0;
  int failures = 0;

  sw_debounce #(.WIDTH(WIDTH), .STABLE_CYCLES(SC)) dut (
    .clock(clock),
    .reset(reset),
    .raw  (raw),
    .clean(clean),
    .rise (rise),
    .fall (fall)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    raw   = 3'b000;
    step(2);
    checks++;
    if ({clean, rise, fall} !== 9'b0) begin
      failures++;
      $display("FAIL reset_state got clean=%b rise=%b fall=%b want all 0", clean, rise, fall);
    end
    reset = 1'b0;
  endtask

  task automatic test_settle;
    raw = 3'b001;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      checks++;
      if ({clean, rise, fall} !== {(i >= 6) ? 3'b001 : 3'b000, (i == 6) ? (PM & 3'b001) : 3'b000, 3'b000}) begin
        failures++;
        $display("FAIL settle edge %0d got clean=%b rise=%b fall=%b", i, clean, rise, fall);
      end
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 12; i++) begin
      raw = (i < 4 && i % 2 == 0) ? 3'b011 : 3'b001;
      step(1);
      checks++;
      if ({clean, rise, fall} !== {3'b001, 3'b000, 3'b000}) begin
        failures++;
        $display("FAIL bounce cycle %0d got clean=%b rise=%b fall=%b want clean=001 no pulses", i, clean, rise, fall);
      end
    end
  endtask

  task automatic test_glitch_then_accept;
    raw = 3'b101;
    step(3);
    raw = 3'b001;
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if ({clean, rise, fall} !== {3'b001, 3'b000, 3'b000}) begin
        failures++;
        $display("FAIL short_glitch cycle %0d got clean=%b rise=%b fall=%b want clean=001", i, clean, rise, fall);
      end
    end
    raw = 3'b101;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      checks++;
      if ({clean, rise, fall} !== {(i >= 6) ? 3'b101 : 3'b001, (i == 6) ? (PM & 3'b100) : 3'b000, 3'b000}) begin
        failures++;
        $display("FAIL accept_ch2 edge %0d got clean=%b rise=%b fall=%b", i, clean, rise, fall);
      end
    end
  endtask

  task automatic test_all_fall;
    raw = 3'b111;
    step(8);
    checks++;
    if (clean !== 3'b111) begin
      failures++;
      $display("FAIL all_high got clean=%b want 111", clean);
    end
    raw = 3'b000;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      checks++;
      if ({clean, rise, fall} !== {(i >= 6) ? 3'b000 : 3'b111, 3'b000, (i == 6) ? PM : 3'b000}) begin
        failures++;
        $display("FAIL all_fall edge %0d got clean=%b rise=%b fall=%b", i, clean, rise, fall);
      end
    end
  endtask

  task automatic test_reset_mid_settle;
    raw = 3'b110;
    step(8);
    checks++;
    if (clean !== 3'b110) begin
      failures++;
      $display("FAIL pre_reset got clean=%b want 110", clean);
    end
    raw = 3'b111;
    step(4);
    reset = 1'b1;
    #1;
    checks++;
    if ({clean, rise, fall} !== 9'b0) begin
      failures++;
      $display("FAIL async_reset got clean=%b rise=%b fall=%b want all 0", clean, rise, fall);
    end
    step(2);
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      checks++;
      if ({clean, rise, fall} !== {(i >= 6) ? 3'b111 : 3'b000, (i == 6) ? PM : 3'b000, 3'b000}) begin
        failures++;
        $display("FAIL post_reset edge %0d got clean=%b rise=%b fall=%b", i, clean, rise, fall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_bounce();
    test_glitch_then_accept();
    test_all_fall();
    test_reset_mid_settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Upstream input-conditioning stage for the board's slide switches and push-buttons. Each raw channel is synchronised into the clock domain, filtered so that only a level held stable for a programmable number of cycles is accepted, and presented as a clean level plus single-cycle rise/fall pulses. The clean levels feed the combinational gate logic (e.g. the cascaded AND that drives LEDR) in place of raw SW bits.

## Interface
- WIDTH, 3 — number of independent input channels.
- STABLE_CYCLES, 16 — consecutive identical synchronised samples required to accept a new level; must be ≥ 2. Synthesis builds for the 50 MHz board clock override this to 1_000_000 (20 ms).
- clock  input  1  — the single clock; all state updates on its rising edge.
- reset  input  1  — asynchronous, active-high; clears all state immediately.
- raw  input  WIDTH  — unsynchronised switch/key levels.
- clean  output  WIDTH  — debounced level per channel.
- rise  output  WIDTH  — one-cycle pulse when clean goes 0→1.
- fall  output  WIDTH  — one-cycle pulse when clean goes 1→0.

## Operation
- Channels are fully independent; no cross-channel interaction.
- Per channel: two-flop synchroniser sync1 → sync2 (call sync2 the sample s), a counter cnt of width $clog2(STABLE_CYCLES), and a 2-state FSM.
- IDLE: if s == clean, stay, cnt = 0. If s != clean, go to SETTLE, cnt <= 1.
- SETTLE: if s == clean (bounce back), go to IDLE, cnt <= 0, clean unchanged, no pulse.
- SETTLE: if s != clean and cnt < STABLE_CYCLES-1, cnt <= cnt+1.
- SETTLE: if s != clean and cnt == STABLE_CYCLES-1, clean <= s, go to IDLE, cnt <= 0, and assert rise (if s=1) or fall (if s=0) for exactly that following cycle.
- rise/fall are registered; never both high on one channel; high for one cycle only.
- The counter never wraps: its maximum reached value is STABLE_CYCLES-1.
- Reset (any time, including mid-SETTLE): sync1, sync2, clean, rise, fall all 0; FSM IDLE; cnt 0. A channel held high through reset is accepted as a normal 0→1 transition after release, producing one rise pulse.

## Timing
- Latency: raw changes and then holds before edge E0. sync1 captures at E0, s updates at E1, first mismatch is sampled at E2, and clean/pulse update at edge E(STABLE_CYCLES+1). Total: STABLE_CYCLES+2 rising edges.
- A glitch shorter than STABLE_CYCLES samples on s never changes clean.
- rise/fall assert in the same cycle that clean shows the new value.
- Reset assertion takes effect without a clock edge. Deassertion is assumed synchronous to clock at system level.

## Configuration
- SW_DEBOUNCE_EDGE_EN defined: rise/fall registers and logic are built as described above.
- SW_DEBOUNCE_EDGE_EN undefined: rise and fall are tied to constant 0 and the pulse logic is removed. Port list and clean timing are unchanged.

## Structure
- Shared package sw_debounce_pkg holds:
  - the FSM state typedef (IDLE, SETTLE);
  - the board constant DEBOUNCE_20MS_AT_50MHZ = 1_000_000.
- Sub-module debounce_channel implements one channel: synchroniser, counter, FSM, pulse registers.
- sw_debounce is a generate loop of WIDTH debounce_channel instances.

## Test plan
Bench configuration: STABLE_CYCLES = 4, WIDTH = 3.
- Reset with raw=3'b000, release, hold raw=3'b001. Required: clean[0] rises at the 6th edge after the change, rise[0] high for exactly 1 cycle, clean[2:1] stays 0.
- raw[1] bounce 1,0,1,0 on successive cycles, then stable 0. Required: clean[1] stays 0, no rise/fall on channel 1.
- raw[2] high for exactly 3 cycles after sync. Required: no change. Then high for 4 cycles. Required: clean[2]=1 and rise[2] pulse.
- clean=3'b111 then raw=3'b000 together. Required: all three fall pulses in the same cycle and clean=3'b000 on the 6th edge.
- Assert reset 2 cycles into SETTLE with raw[0]=1. Required: outputs 0 immediately. After release, clean[0]=1 on the 6th edge following release.
- Build without SW_DEBOUNCE_EDGE_EN and repeat the first scenario. Required: same clean timing, rise/fall constant 0.
